// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the 7-segment scan controller
// Contents: state_t (ST_GUARD, ST_SHOW), default NDIG/DIV/GUARD values, BCD nibble width.
package seg_scan_pkg;

  localparam int NDIG_DEF  = 4;
  localparam int DIV_DEF   = 1000;
  localparam int GUARD_DEF = 2;
  localparam int BCD_W     = 4;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_slot_timer.sv
// rtl/seg_slot_timer.sv - per-slot prescaler with guard-end and slot-end strobes
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   guard_end  : high on the last cycle of the guard phase (prescaler == GUARD-1)
//   slot_end   : high on the last cycle of the slot (prescaler == DIV-1)
import seg_scan_pkg::*;

module seg_slot_timer #(
  parameter int DIV   = DIV_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic guard_end,
  output logic slot_end
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;

  assign guard_end = (presc == PW'(GUARD - 1));
  assign slot_end  = (presc == PW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (slot_end) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed scan controller sharing one BCD-to-7-segment decoder
// Optional feature macro: SEG_LZB_EN (leading-zero blanking via bi_rbo).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load, value : double-buffered display update, accepted only while ready=1
//   ready       : no update pending
//   bcd         : digit code to the decoder
//   bi_rbo      : active-low blank to the decoder
//   an          : one-hot active-high digit enable, zero while blank
//   frame_done  : one-cycle pulse after each full scan
import seg_scan_pkg::*;

module seg_scan_ctrl #(
  parameter int NDIG  = NDIG_DEF,
  parameter int DIV   = DIV_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BCD_W*NDIG-1:0]   value,
  output logic                    ready,
  output logic [BCD_W-1:0]        bcd,
  output logic                    bi_rbo,
  output logic [NDIG-1:0]         an,
  output logic                    frame_done
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [NDIG-1:0] AN_ONE = NDIG'(1);

  state_t                  state, state_next;
  logic [IW-1:0]           idx;
  logic [BCD_W*NDIG-1:0]   shadow, active;
  logic                    pending;
  logic                    guard_end, slot_end;
  logic                    boundary;
  logic                    blank;
  logic [BCD_W-1:0]        cur_nib;

  seg_slot_timer #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .guard_end (guard_end),
    .slot_end  (slot_end)
  );

  assign cur_nib  = active[int'(idx)*BCD_W +: BCD_W];
  // slot_end can only occur in SHOW because GUARD < DIV
  assign boundary = slot_end && (idx == '0);
  assign ready    = ~pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_GUARD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_GUARD: if (guard_end) state_next = ST_SHOW;
      ST_SHOW:  if (slot_end)  state_next = ST_GUARD;
      default:  state_next = ST_GUARD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= IW'(NDIG - 1);
    end else if (slot_end) begin
      idx <= (idx == '0) ? IW'(NDIG - 1) : idx - 1'b1;
    end
  end

  // A load accepted on the boundary cycle sees pending=0 here, so it waits a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (boundary && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (load && !pending) begin
      shadow  <= value;
      pending <= 1'b1;
    end
  end

`ifdef SEG_LZB_EN
  logic rb;

  // rb stays set while every digit scanned so far in this frame was zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb <= 1'b1;
    end else if (slot_end) begin
      if (idx == '0)            rb <= 1'b1;
      else if (cur_nib != '0)   rb <= 1'b0;
    end
  end

  assign blank = rb && (cur_nib == '0) && (idx != '0);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '0;
      bcd        <= '0;
      bi_rbo     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bcd        <= cur_nib;
      frame_done <= boundary;
      if (state == ST_SHOW && !blank) begin
        an     <= AN_ONE << idx;
        bi_rbo <= 1'b1;
      end else begin
        an     <= '0;
        bi_rbo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl against a slot/frame reference model
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        ready;
  logic [3:0]  bcd;
  logic        bi_rbo;
  logic [3:0]  an;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;
  int cnt = 0;

  logic [15:0] m_shadow, m_active;
  bit          m_pending;

  seg_scan_ctrl #(
    .NDIG  (NDIG),
    .DIV   (DIV),
    .GUARD (GUARD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .ready      (ready),
    .bcd        (bcd),
    .bi_rbo     (bi_rbo),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic bit lz_blank(input logic [15:0] v, input int d);
`ifdef SEG_LZB_EN
    if (d == 0) return 1'b0;
    return ((v >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cnt);
    end
  endtask

  task automatic model_reset();
    m_shadow  = 16'h0;
    m_active  = 16'h0;
    m_pending = 1'b0;
    cnt       = 0;
  endtask

  // One clock: outputs after edge reflect the slot position of the cycle before it.
  task automatic cyc(input bit ld, input logic [15:0] val);
    int         c, ph, d;
    bit         bnd, blk;
    logic [3:0] e_an, e_bcd;
    logic       e_bi;
    load  = ld;
    value = val;
    @(posedge clk);
    #1;
    c   = cnt;
    cnt++;
    ph  = c % DIV;
    d   = NDIG - 1 - ((c / DIV) % NDIG);
    bnd = ((c % FRAME) == FRAME - 1);
    blk = lz_blank(m_active, d);
    e_bcd = 4'(m_active >> (4 * d));
    if (ph < GUARD || blk) begin
      e_an = 4'h0;
      e_bi = 1'b0;
    end else begin
      e_an = 4'(1 << d);
      e_bi = 1'b1;
    end
    if (bnd && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end else if (ld && !m_pending) begin
      m_shadow  = val;
      m_pending = 1'b1;
    end
    chk("an", 16'(an), 16'(e_an));
    chk("bi_rbo", 16'(bi_rbo), 16'(e_bi));
    chk("bcd", 16'(bcd), 16'(e_bcd));
    chk("frame_done", 16'(frame_done), 16'(bnd));
    chk("ready", 16'(ready), 16'(!m_pending));
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom));
  endtask

  initial begin
    logic [15:0] rv;
    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    #1;
    chk("rst_an", 16'(an), 16'h0);
    chk("rst_bi", 16'(bi_rbo), 16'h0);
    chk("rst_bcd", 16'(bcd), 16'h0);
    chk("rst_fd", 16'(frame_done), 16'h0);
    chk("rst_ready", 16'(ready), 16'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // basic scan, loaded right after reset
    cyc(1'b1, 16'h1234);
    run(2 * FRAME);

    // second load while pending is ignored
    cyc(1'b1, 16'h1111);
    cyc(1'b1, 16'h2222);
    cyc(1'b1, 16'h2222);
    run(2 * FRAME);

    // load on the boundary cycle defers one frame
    while ((cnt % FRAME) != FRAME - 1) cyc(1'b0, 16'h0);
    cyc(1'b1, 16'h5678);
    run(2 * FRAME + 4);

    // leading-zero patterns
    cyc(1'b1, 16'h0045);
    run(2 * FRAME);
    cyc(1'b1, 16'h0000);
    run(2 * FRAME);
    cyc(1'b1, 16'h1005);
    run(2 * FRAME);

    // randomized loads with random leading-zero counts
    for (int i = 0; i < 400; i++) begin
      rv = 16'($urandom);
      rv = rv & (16'hFFFF >> (4 * ($urandom % 4)));
      cyc(($urandom % 6) == 0, rv);
    end

    // asynchronous reset in the middle of a SHOW phase with an update pending
    cyc(1'b0, 16'h0);
    while (m_pending) cyc(1'b0, 16'h0);
    cyc(1'b1, 16'h9876);
    while ((cnt % DIV) != 4) cyc(1'b0, 16'h0);
    chk("pre_rst_an_live", 16'(an != 4'h0), 16'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_an", 16'(an), 16'h0);
    chk("async_rst_bi", 16'(bi_rbo), 16'h0);
    chk("async_rst_ready", 16'(ready), 16'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run(FRAME + 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-cathode 7-segment display. It sits in front of the team's single BCD-to-7-segment decoder (bcd[3:0] in, active-low BI_RBO blank input) and shares that one decoder between NDIG digit positions. It cycles the digit enables, presents each digit's BCD code, inserts ghost-suppression guard time, and double-buffers display updates through a load/ready handshake. Optional leading-zero blanking drives the decoder's blank input.

## Interface
- NDIG, 4: number of digit positions, ≥2.
- DIV, 1000: clock cycles per digit slot.
- GUARD, 2: blank cycles at the start of each slot, 1 ≤ GUARD < DIV.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  request to latch value; accepted only when ready=1.
- value  in  4*NDIG  packed BCD; nibble k is digit k, with digit 0 as the least significant.
- ready  out  1  high when no update is pending.
- bcd  out  4  BCD code to the decoder.
- bi_rbo  out  1  active-low blank to the decoder; 0 means blank.
- an  out  NDIG  one-hot digit enable, active-high; all zero when blank.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Registers:
  - shadow and active: 4*NDIG bits each.
  - pending: 1 bit.
  - prescaler: $clog2(DIV) bits.
  - digit index: max(1,$clog2(NDIG)) bits.
  - rb: ripple-blank flag.
  - state.
- Scan order runs from digit NDIG-1 down to digit 0, then wraps to NDIG-1.
- Each slot lasts DIV cycles and has two phases:
  - GUARD: the first GUARD cycles. an=0, bi_rbo=0, and bcd holds the slot's digit code.
  - SHOW: the remaining DIV-GUARD cycles. bcd=active nibble[idx], an=one-hot(idx), bi_rbo=1 unless the digit is blanked.
- State machine:
  - GUARD→SHOW when prescaler==GUARD-1.
  - SHOW→GUARD when prescaler==DIV-1. At that point the prescaler returns to 0 and the index decrements, wrapping from 0 to NDIG-1.
- Frame boundary is the last cycle of digit 0's SHOW phase. On that cycle:
  - frame_done=1 on the following cycle (registered).
  - If pending=1: active←shadow, pending←0.
- Load handshake:
  - ready=~pending.
  - load&&ready: shadow←value, pending←1.
  - load while pending=1 is ignored, and shadow is unchanged.
  - If load is accepted on the boundary cycle itself, it does not transfer at that boundary; it transfers at the next one.
- Invalid nibbles (>9) are passed to bcd unchanged and are not blanked by this block.
- All outputs are registered.

## Timing
- Reset values:
  - an=0, bcd=0, bi_rbo=0, frame_done=0, ready=1.
  - shadow=0, active=0, pending=0, prescaler=0.
  - idx=NDIG-1, state=GUARD, rb=1.
- Reset takes effect immediately (asynchronous). On release, the first GUARD phase starts on the first clock edge.
- Frame period is NDIG*DIV cycles. frame_done pulses once per frame.
- Latency from an accepted load to the new value on digit NDIG-1's SHOW is between GUARD+1 and NDIG*DIV+GUARD+1 cycles.
- Output changes are registered, one cycle after the internal state transition.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking is enabled.
  - rb is set to 1 at the start of digit NDIG-1's slot.
  - If rb=1 and the nibble is 0 and idx≠0, the digit is blanked for the whole slot: an=0, bi_rbo=0.
  - Any nonzero nibble clears rb for the rest of the frame.
  - Digit 0 is never blanked.
- SEG_LZB_EN undefined: rb logic is absent, and every digit shows in SHOW with bi_rbo=1.

## Structure
- Package seg_scan_pkg holds:
  - state enum (ST_GUARD, ST_SHOW).
  - Default parameter constants.
  - The BCD nibble width constant (4).
- Sub-module seg_slot_timer holds the prescaler and phase compare logic. Outputs: guard_end and slot_end strobes. The top level owns the index, rb, buffers and outputs.

## Test plan
All scenarios use NDIG=4, DIV=8, GUARD=2.
- Reset: assert rst mid-SHOW → an=0, bi_rbo=0, ready=1 in the same cycle, without waiting for a clock edge.
- Basic scan: load 0x1234 right after reset → ready=0 until the first boundary. Then for each 8-cycle slot:
  - Digit 3: an=0 for 2 cycles, then an=4'b1000, bcd=1 for 6 cycles.
  - Digits 2, 1, 0 follow the same pattern, showing 2, 3, 4.
  - frame_done pulses every 32 cycles.
- Handshake: load 0x1111, then load 0x2222 while ready=0 → 0x1111 is displayed, and 0x2222 never appears.
- Boundary load: load 0x5678 on the boundary cycle with ready=1 → the old value persists for one more frame, then 0x5678 appears.
- With SEG_LZB_EN:
  - Load 0x0045 → digits 3 and 2 have an=0, bi_rbo=0 for their whole slots; digits 1 and 0 show 4 and 5.
  - Load 0x0000 → only digit 0 shows 0.
  - Load 0x1005 → all four digits shown.
- Without SEG_LZB_EN: load 0x0045 → all digits enabled, showing 0, 0, 4, 5.
